// File: rtl/router_pkg.sv
// ============================================================================
// Module   : router_pkg
// Brief    : Shared router constants so the FSM, FIFOs and synchroniser agree.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;
   localparam int DEF_NUM_PORTS = 3;
   localparam int DEF_ADDR_W    = 2;
   localparam int DEF_TIMEOUT   = 30;
   localparam int DEF_CNT_W     = 5;
   localparam int MIN_TIMEOUT   = 2;
endpackage

`default_nettype wire

// File: rtl/router_watchdog.sv
// ============================================================================
// Module   : router_watchdog
// Brief    : One port's read-timeout counter; pulses soft_reset on a stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_watchdog #(
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             vld,
   input  logic             rd,
   input  logic [CNT_W-1:0] timeout_q,
   output logic             soft_reset
);

   logic [CNT_W-1:0] r_count;
   logic             r_soft_reset;
   logic             w_terminal;

   assign w_terminal = (r_count == (timeout_q - CNT_W'(1)));

   // A read in the same cycle as the terminal count wins and suppresses the pulse.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_count      <= '0;
         r_soft_reset <= 1'b0;
      end else if (!vld || rd) begin
         r_count      <= '0;
         r_soft_reset <= 1'b0;
      end else if (w_terminal) begin
         r_count      <= '0;
         r_soft_reset <= 1'b1;
      end else begin
         r_count      <= r_count + CNT_W'(1);
         r_soft_reset <= 1'b0;
      end
   end

   assign soft_reset = r_soft_reset;

endmodule

`default_nettype wire

// File: rtl/router_sync_n.sv
// ============================================================================
// Module   : router_sync_n
// Brief    : 1xN router synchroniser: address latch, write steering, watchdogs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_sync_n
   import router_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 detect_add,
   input  logic                 write_enb_reg,
   input  logic [NUM_PORTS-1:0] full,
   input  logic [NUM_PORTS-1:0] empty,
   input  logic [NUM_PORTS-1:0] read_enb,
   input  logic                 cfg_we,
   input  logic [CNT_W-1:0]     cfg_timeout,
   output logic                 fifo_full,
   output logic [NUM_PORTS-1:0] write_enb,
   output logic [NUM_PORTS-1:0] vld_out,
   output logic [NUM_PORTS-1:0] soft_reset,
   output logic                 addr_err,
   output logic [CNT_W-1:0]     timeout_q
);

   localparam logic [ADDR_W:0]    c_NUM_PORTS   = (ADDR_W+1)'(NUM_PORTS);
   localparam logic [CNT_W-1:0]   c_MIN_TIMEOUT = CNT_W'(MIN_TIMEOUT);
   localparam logic [CNT_W-1:0]   c_TIMEOUT_RST = CNT_W'(TIMEOUT);

   logic [ADDR_W-1:0] r_addr_q;
   logic [CNT_W-1:0]  r_timeout;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_addr_q <= '0;
      end else if (detect_add) begin
         r_addr_q <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_timeout <= c_TIMEOUT_RST;
      end else if (cfg_we && (cfg_timeout >= c_MIN_TIMEOUT)) begin
         r_timeout <= cfg_timeout;
      end
   end

   assign addr_err  = ({1'b0, r_addr_q} >= c_NUM_PORTS);
   assign timeout_q = r_timeout;
   assign vld_out   = ~empty;

   // An out-of-range address matches no port, so both outputs fall to zero.
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_addr_q == ADDR_W'(i)) begin
            fifo_full    = full[i];
            write_enb[i] = write_enb_reg;
         end
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wd
      router_watchdog #(
         .CNT_W (CNT_W)
      ) u_wd (
         .clock      (clock),
         .resetn     (resetn),
         .vld        (vld_out[g]),
         .rd         (read_enb[g]),
         .timeout_q  (r_timeout),
         .soft_reset (soft_reset[g])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_router_sync_n.sv
// ============================================================================
// Module   : tb_router_sync_n
// Brief    : Self-checking bench for router_sync_n (default and 5-port builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_sync_n;

   logic       clock = 1'b0;
   logic       resetn;
   always #5 clock = ~clock;

   // Default build: 3 ports
   logic [1:0] data_in;
   logic       detect_add, write_enb_reg, cfg_we;
   logic [2:0] full, empty, read_enb;
   logic [4:0] cfg_timeout;
   logic       fifo_full, addr_err;
   logic [2:0] write_enb, vld_out, soft_reset;
   logic [4:0] timeout_q;

   // 5-port build
   logic [2:0] b_data_in;
   logic       b_detect_add, b_write_enb_reg, b_cfg_we;
   logic [4:0] b_full, b_empty, b_read_enb;
   logic [4:0] b_cfg_timeout;
   logic       b_fifo_full, b_addr_err;
   logic [4:0] b_write_enb, b_vld_out, b_soft_reset;
   logic [4:0] b_timeout_q;

   router_sync_n dut_a (
      .clock(clock), .resetn(resetn), .data_in(data_in), .detect_add(detect_add),
      .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
      .cfg_we(cfg_we), .cfg_timeout(cfg_timeout), .fifo_full(fifo_full),
      .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset),
      .addr_err(addr_err), .timeout_q(timeout_q)
   );

   router_sync_n #(.NUM_PORTS(5), .ADDR_W(3), .TIMEOUT(30), .CNT_W(5)) dut_b (
      .clock(clock), .resetn(resetn), .data_in(b_data_in), .detect_add(b_detect_add),
      .write_enb_reg(b_write_enb_reg), .full(b_full), .empty(b_empty), .read_enb(b_read_enb),
      .cfg_we(b_cfg_we), .cfg_timeout(b_cfg_timeout), .fifo_full(b_fifo_full),
      .write_enb(b_write_enb), .vld_out(b_vld_out), .soft_reset(b_soft_reset),
      .addr_err(b_addr_err), .timeout_q(b_timeout_q)
   );

   typedef struct {
      logic [1:0] di;
      logic       det;
      logic       we;
      logic [2:0] full;
      logic [2:0] empty;
      logic [2:0] exp_we;
      logic       exp_ff;
      logic       exp_err;
      logic [2:0] exp_vld;
   } vec_t;

   vec_t vecs[9];
   vec_t sb_q[$];
   vec_t e;
   int   exp_q[$];
   int   q1[$];
   int   q4[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Stall port 0 of the default build; pulses are matched against exp_q.
   task automatic stall_a(input int n_edges, input int rd_at);
      for (int k = 1; k <= n_edges; k++) begin
         read_enb = (k == rd_at) ? 3'b001 : 3'b000;
         tick();
         if (soft_reset[0]) begin
            if (exp_q.size() == 0) chk("pulse_unexpected_edge", k, 0);
            else                   chk("pulse_edge", k, exp_q.pop_front());
         end
         if (soft_reset[2:1] != 2'b00) chk("idle_port_pulse", {29'd0, soft_reset}, 0);
      end
      read_enb = 3'b000;
      chk("pulse_missed", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      resetn = 1'b0;
      data_in = '0; detect_add = 0; write_enb_reg = 0; cfg_we = 0; cfg_timeout = '0;
      full = 3'b001; empty = 3'b111; read_enb = 3'b000;
      b_data_in = '0; b_detect_add = 0; b_write_enb_reg = 0; b_cfg_we = 0; b_cfg_timeout = '0;
      b_full = '0; b_empty = 5'b11111; b_read_enb = '0;

      tick(); tick();
      chk("rst_write_enb", write_enb, 0);
      chk("rst_soft_reset", soft_reset, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_timeout_q", timeout_q, 30);
      chk("rst_fifo_full", fifo_full, 1);
      chk("rst_vld_out", vld_out, 0);
      resetn = 1'b1;

      // Rows: inputs during a cycle and the outputs expected in that same cycle.
      vecs = '{
         '{2'd2, 1'b1, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000},
         '{2'd0, 1'b0, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 1'b0, 3'b000},
         '{2'd0, 1'b0, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 1'b0, 3'b000},
         '{2'd1, 1'b1, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 1'b0, 3'b000},
         '{2'd0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b010, 1'b1, 1'b0, 3'b101},
         '{2'd3, 1'b1, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000},
         '{2'd0, 1'b0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000},
         '{2'd0, 1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000},
         '{2'd0, 1'b0, 1'b1, 3'b001, 3'b110, 3'b001, 1'b1, 1'b0, 3'b001}
      };
      for (int i = 0; i < 9; i++) begin
         data_in = vecs[i].di; detect_add = vecs[i].det; write_enb_reg = vecs[i].we;
         full = vecs[i].full; empty = vecs[i].empty;
         sb_q.push_back(vecs[i]);
         #1;
         e = sb_q.pop_front();
         chk($sformatf("vec%0d_write_enb", i), write_enb, e.exp_we);
         chk($sformatf("vec%0d_fifo_full", i), fifo_full, e.exp_ff);
         chk($sformatf("vec%0d_addr_err", i), addr_err, e.exp_err);
         chk($sformatf("vec%0d_vld_out", i), vld_out, e.exp_vld);
         tick();
      end
      detect_add = 0; write_enb_reg = 0; empty = 3'b111; full = 3'b001;
      tick();

      // Unread stall: pulses after 30 and 60 cycles
      empty = 3'b110;
      exp_q = '{30, 60};
      stall_a(65, 0);
      empty = 3'b111; tick();

      // Read on cycle 29 restarts the count
      empty = 3'b110;
      exp_q = '{59};
      stall_a(60, 29);
      empty = 3'b111; tick();

      // Reset mid-count, with a non-default timeout and address beforehand
      cfg_we = 1; cfg_timeout = 5'd31; detect_add = 1; data_in = 2'd2;
      tick();
      cfg_we = 0; detect_add = 0;
      chk("cfg31_timeout_q", timeout_q, 31);
      chk("pre_rst_fifo_full", fifo_full, 0);
      empty = 3'b110;
      stall_a(20, 0);
      resetn = 1'b0;
      tick();
      chk("midrst_soft_reset", soft_reset, 0);
      chk("midrst_timeout_q", timeout_q, 30);
      chk("midrst_write_enb", write_enb, 0);
      chk("midrst_addr_err", addr_err, 0);
      chk("midrst_fifo_full", fifo_full, 1);
      resetn = 1'b1;
      exp_q = '{30};
      stall_a(31, 0);
      empty = 3'b111; tick();

      // Programmable timeout; 1 and 0 are ignored
      cfg_we = 1; cfg_timeout = 5'd5; tick();
      chk("cfg5_timeout_q", timeout_q, 5);
      cfg_timeout = 5'd1; tick();
      chk("cfg1_ignored", timeout_q, 5);
      cfg_timeout = 5'd0; tick();
      chk("cfg0_ignored", timeout_q, 5);
      cfg_we = 0;
      empty = 3'b110;
      exp_q = '{5, 10, 15};
      stall_a(17, 0);
      empty = 3'b111; tick();

      // 5-port build: address sweep
      b_full = 5'b11111; b_write_enb_reg = 1;
      for (int a = 0; a < 8; a++) begin
         b_data_in = 3'(a); b_detect_add = 1;
         tick();
         b_detect_add = 0;
         #1;
         chk($sformatf("b_addr%0d_write_enb", a), b_write_enb, (a < 5) ? (32'd1 << a) : 32'd0);
         chk($sformatf("b_addr%0d_addr_err", a), b_addr_err, (a >= 5) ? 1 : 0);
         chk($sformatf("b_addr%0d_fifo_full", a), b_fifo_full, (a < 5) ? 1 : 0);
      end
      b_write_enb_reg = 0;
      tick();

      // 5-port build: staggered concurrent stalls on ports 1 and 4
      q1 = '{30, 60};
      q4 = '{37, 67};
      b_empty = 5'b11101;
      for (int k = 1; k <= 70; k++) begin
         if (k == 8) b_empty = 5'b01101;
         tick();
         if (b_soft_reset[1]) begin
            if (q1.size() == 0) chk("b_p1_unexpected_edge", k, 0);
            else                chk("b_p1_pulse_edge", k, q1.pop_front());
         end
         if (b_soft_reset[4]) begin
            if (q4.size() == 0) chk("b_p4_unexpected_edge", k, 0);
            else                chk("b_p4_pulse_edge", k, q4.pop_front());
         end
         if ((b_soft_reset & 5'b01101) != 5'b00000) chk("b_idle_port_pulse", {27'd0, b_soft_reset}, 0);
      end
      chk("b_p1_missed", q1.size(), 0);
      chk("b_p4_missed", q4.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised successor of the 1xN router synchroniser, sitting between the router FSM, the N output FIFOs and the downstream readers.
- Latches the destination address at packet header and steers the FSM write strobe to one FIFO.
- Returns the selected FIFO's full flag to the FSM and drives per-port valid outputs.
- Runs a per-port read-timeout watchdog that pulses soft_reset on a stalled port. The timeout is runtime-programmable, and out-of-range addresses are flagged.

Parameters:
NUM_PORTS, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, destination address width; must satisfy 2**ADDR_W >= NUM_PORTS
TIMEOUT, 30, reset value of the timeout register, in cycles (>= 2)
CNT_W, 5, watchdog counter/timeout register width; must hold TIMEOUT

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  reset, synchronous, active-low
data_in  in  ADDR_W  header address bits, sampled when detect_add=1
detect_add  in  1  FSM header-detect strobe
write_enb_reg  in  1  FSM write request for current packet
full  in  NUM_PORTS  FIFO full flags, bit i = port i
empty  in  NUM_PORTS  FIFO empty flags
read_enb  in  NUM_PORTS  downstream read strobes
cfg_we  in  1  load cfg_timeout into timeout register
cfg_timeout  in  CNT_W  new timeout value; 0 and 1 are ignored
fifo_full  out  1  full flag of the latched destination
write_enb  out  NUM_PORTS  one-hot FIFO write enables
vld_out  out  NUM_PORTS  per-port data-available (~empty)
soft_reset  out  NUM_PORTS  one-cycle watchdog reset pulse per FIFO
addr_err  out  1  latched address >= NUM_PORTS
timeout_q  out  CNT_W  current timeout register value

Behaviour:
Address latch
- addr_q is a register. Reset value 0.
- Loads data_in on any cycle with detect_add=1. Holds otherwise.
- If detect_add and write_enb_reg are high in the same cycle, write_enb decodes the old addr_q; the new address takes effect next cycle.

Combinational outputs (all from addr_q)
- addr_err = (addr_q >= NUM_PORTS).
- write_enb: bit addr_q = write_enb_reg when addr_err=0; all zero when addr_err=1 or write_enb_reg=0. Never more than one bit set.
- fifo_full = full[addr_q] when addr_err=0, else 0.
- vld_out[i] = ~empty[i], purely combinational.

Timeout register
- Reset value TIMEOUT.
- Loads cfg_timeout on cfg_we=1 if cfg_timeout >= 2; otherwise holds.
- A load while counters are running affects comparisons from the next cycle; no counter is cleared by it.

Per-port watchdog (independent for each i, count_i is CNT_W bits, all registered)
- resetn=0: count_i=0, soft_reset[i]=0.
- vld_out[i]=0: count_i=0, soft_reset[i]=0.
- vld_out[i]=1 and read_enb[i]=1: count_i=0, soft_reset[i]=0. A read wins over timeout in the same cycle.
- vld_out[i]=1, read_enb[i]=0, count_i == timeout_q-1: count_i=0, soft_reset[i]=1 for exactly one cycle.
- Otherwise, with vld_out[i]=1: count_i+1, soft_reset[i]=0.
- Result: the first pulse occurs on the edge ending the timeout_q-th consecutive unread valid cycle. It then repeats every timeout_q cycles while the stall persists.
- No wrap-around is possible because timeout_q <= 2**CNT_W-1.
- Reset asserted mid-count clears all state on that edge. The outputs after reset are: fifo_full=full[0], write_enb=0, soft_reset=0, addr_err=0, timeout_q=TIMEOUT.

Latency
- write_enb, fifo_full and addr_err: zero cycles from addr_q/write_enb_reg/full.
- soft_reset: registered, one cycle after the terminal count condition.

Decomposition:
- Shared package router_pkg holds DEF_NUM_PORTS, DEF_TIMEOUT and the min-timeout constant (2), so the FIFO and FSM use identical port counts.
- Natural sub-module: router_watchdog (one port's counter plus soft_reset; inputs vld, rd, timeout_q), instantiated NUM_PORTS times by a generate loop.
- The top level holds the address latch, the decode/mux and the timeout register.

Test Plan:
- Default params; detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100 on the next cycle; full=3'b100 -> fifo_full=1; full=3'b011 -> fifo_full=0.
- data_in=3 latched -> addr_err=1; write_enb_reg=1 -> write_enb=000 and fifo_full=0 even with full=111.
- empty[0]=0 held, read_enb[0]=0 -> soft_reset[0]=1 for one cycle after the 30th valid cycle, then again 30 cycles later. read_enb[0]=1 on cycle 29 -> no pulse, count restarts.
- cfg_we with cfg_timeout=5 -> timeout_q=5 and the stall pulse comes after 5 cycles; cfg_timeout=1 -> timeout_q unchanged.
- resetn=0 mid-count at count 20 -> soft_reset stays 0; after release a full timeout_q unread cycles is needed before the next pulse, and timeout_q returns to 30.
- NUM_PORTS=5, ADDR_W=3: sweep addresses 0..7 with write_enb_reg=1 -> one-hot write_enb for 0..4, addr_err=1 for 5..7. Concurrent stalls on ports 1 and 4 give independent pulses.
